// File: rtl/adder_sum_accumulator.sv
// Frame accumulator for the 33-bit {carry, sum} terms coming out of adder_32bit.
// Terms are summed per frame; the result is held until the consumer takes it.
module adder_sum_accumulator #(
    parameter int ACC_WIDTH = 41,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_sum,
    input  logic                 in_carry,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_total,
    output logic [CNT_WIDTH:0]   out_count,
    output logic                 out_overflow,
    output logic                 out_forced
);

    localparam logic [CNT_WIDTH:0] CNT_LIMIT = {1'b1, {CNT_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH:0] CNT_ONE   = {{CNT_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] total;
        logic [CNT_WIDTH:0]   count;
        logic                 overflow;
        logic                 forced;
    } result_t;

    state_t               state, state_n;
    result_t              res;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] term;
    logic [ACC_WIDTH:0]   sum_full;
    logic [CNT_WIDTH:0]   cnt;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 ovf;
    logic                 ovf_inc;
    logic                 limit_hit;
    logic                 accept;
    logic                 close;
    logic                 release_res;

    assign term      = ACC_WIDTH'({in_carry, in_sum});
    // Extra top bit of the add is the carry that leaves the accumulator.
    assign sum_full  = {1'b0, acc} + {1'b0, term};
    assign cnt_inc   = cnt + CNT_ONE;
    assign ovf_inc   = ovf | sum_full[ACC_WIDTH];
    assign limit_hit = (cnt_inc == CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        close       = 1'b0;
        release_res = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                close    = accept && (in_last || limit_hit);
                if (close) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid   = 1'b1;
                release_res = out_ready;
                if (out_ready) begin
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            res <= '0;
        end else if (accept) begin
            acc <= sum_full[ACC_WIDTH-1:0];
            cnt <= cnt_inc;
            ovf <= ovf_inc;
            if (close) begin
                res.total    <= sum_full[ACC_WIDTH-1:0];
                res.count    <= cnt_inc;
                res.overflow <= ovf_inc;
                res.forced   <= limit_hit;
            end
        end else if (release_res) begin
            // Running state is cleared only once the result has been taken.
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    assign out_total    = res.total;
    assign out_count    = res.count;
    assign out_overflow = res.overflow;
    assign out_forced   = res.forced;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Randomized bench for adder_sum_accumulator: three parameterizations share stimulus,
// one is selected at a time and scored against a frame-level arithmetic model.
module tb_adder_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_sum;
    logic        in_carry;
    logic        in_last;
    logic        out_ready;

    logic        rdy0, ov0, ovf0, frc0;
    logic [40:0] tot0;
    logic [8:0]  cnt0;
    logic        rdy1, ov1, ovf1, frc1;
    logic [33:0] tot1;
    logic [8:0]  cnt1;
    logic        rdy2, ov2, ovf2, frc2;
    logic [40:0] tot2;
    logic [2:0]  cnt2;

    always #5 clk = ~clk;

    adder_sum_accumulator #(.ACC_WIDTH(41), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_sum(in_sum),
        .in_carry(in_carry), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
        .out_total(tot0), .out_count(cnt0), .out_overflow(ovf0), .out_forced(frc0));

    adder_sum_accumulator #(.ACC_WIDTH(34), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_sum(in_sum),
        .in_carry(in_carry), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_total(tot1), .out_count(cnt1), .out_overflow(ovf1), .out_forced(frc1));

    adder_sum_accumulator #(.ACC_WIDTH(41), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_sum(in_sum),
        .in_carry(in_carry), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
        .out_total(tot2), .out_count(cnt2), .out_overflow(ovf2), .out_forced(frc2));

    int          sel;
    logic        s_rdy, s_ov, s_ovf, s_frc;
    logic [63:0] s_tot, s_cnt;

    always_comb begin
        s_rdy = rdy0; s_ov = ov0; s_ovf = ovf0; s_frc = frc0;
        s_tot = 64'(tot0); s_cnt = 64'(cnt0);
        if (sel == 1) begin
            s_rdy = rdy1; s_ov = ov1; s_ovf = ovf1; s_frc = frc1;
            s_tot = 64'(tot1); s_cnt = 64'(cnt1);
        end else if (sel == 2) begin
            s_rdy = rdy2; s_ov = ov2; s_ovf = ovf2; s_frc = frc2;
            s_tot = 64'(tot2); s_cnt = 64'(cnt2);
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: true (unbounded) sum, wrapped only when reported.
    typedef struct {
        longint unsigned tot;
        int              cnt;
        bit              ovf;
        bit              frc;
    } exp_t;

    exp_t            expq[$];
    longint unsigned m_sum;
    int              m_cnt;

    function automatic int acc_w();
        return (sel == 1) ? 34 : 41;
    endfunction

    function automatic int frame_max();
        return (sel == 2) ? 4 : 256;
    endfunction

    function automatic longint unsigned wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic model_accept(input longint unsigned t, input bit last);
        exp_t e;
        m_sum += t;
        m_cnt++;
        if (last || m_cnt == frame_max()) begin
            e.tot = m_sum & wmask(acc_w());
            e.cnt = m_cnt;
            e.ovf = (m_sum >> acc_w()) != 0;
            e.frc = (m_cnt == frame_max());
            expq.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    int          cyc = 0;
    int          acc_cyc;
    int          hs_cyc;
    int          ov_cycles;
    logic [63:0] last_tot, last_cnt;
    logic        last_ovf, last_frc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_ov) ov_cycles++;
            if (s_ov && out_ready) begin
                hs_cyc = cyc + 1;
                last_tot = s_tot; last_cnt = s_cnt; last_ovf = s_ovf; last_frc = s_frc;
                if (expq.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("out_total", s_tot, e.tot);
                    chk("out_count", s_cnt, 64'(e.cnt));
                    chk("out_overflow", 64'(s_ovf), 64'(e.ovf));
                    chk("out_forced", 64'(s_frc), 64'(e.frc));
                end
            end
        end
    end

    task automatic send(input logic [31:0] s, input logic c, input logic l);
        int  n = 0;
        bit  done = 0;
        in_valid = 1'b1; in_sum = s; in_carry = c; in_last = l;
        while (!done) begin
            @(negedge clk);
            if (s_rdy) begin
                model_accept({31'd0, c, s}, l);
                acc_cyc = cyc + 1;
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    chk("send_timeout", 64'd0, 64'd1);
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        expq.delete();
        m_sum = 0;
        m_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned ref64;
        logic [31:0]     a, b;
        logic [32:0]     ab;
        logic [63:0]     snap_tot, snap_cnt;
        int              first_acc;

        sel = 0; rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0;
        in_last = 1'b0; out_ready = 1'b1; m_sum = 0; m_cnt = 0; ov_cycles = 0;
        hs_cyc = 0; acc_cyc = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(s_rdy), 64'd0);
        chk("rst_out_valid", 64'(s_ov), 64'd0);
        chk("rst_total", s_tot, 64'd0);
        chk("rst_count", s_cnt, 64'd0);
        chk("rst_flags", {62'd0, s_ovf, s_frc}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(s_rdy), 64'd1);
        @(posedge clk); #1;

        // three-term frame
        ov_cycles = 0;
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        first_acc = acc_cyc;
        send(32'd1, 1'b0, 1'b0);
        send(32'd5, 1'b0, 1'b1);
        chk("throughput", 64'(acc_cyc - first_acc), 64'd2);
        idle(4);
        chk("f3_valid_cycles", 64'(ov_cycles), 64'd1);
        chk("f3_total", last_tot, 64'h2_0000_0005);
        chk("f3_count", last_cnt, 64'd3);
        chk("f3_flags", {62'd0, last_ovf, last_frc}, 64'd0);

        // 100 random adder results
        ref64 = 0;
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            b = $urandom;
            ab = {1'b0, a} + {1'b0, b};
            ref64 += 64'(a) + 64'(b);
            send(ab[31:0], ab[32], i == 99);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        chk("rand_total", last_tot, ref64 & wmask(41));
        chk("rand_count", last_cnt, 64'd100);

        // output back-pressure
        out_ready = 1'b0;
        send(32'd3, 1'b0, 1'b0);
        send(32'd9, 1'b0, 1'b1);
        in_valid = 1'b1; in_sum = 32'd2; in_carry = 1'b0; in_last = 1'b1;
        @(negedge clk);
        snap_tot = s_tot;
        snap_cnt = s_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_ready", 64'(s_rdy), 64'd0);
            chk("hold_valid", 64'(s_ov), 64'd1);
            chk("hold_total", s_tot, snap_tot);
            chk("hold_count", s_cnt, snap_cnt);
            @(posedge clk); #1;
        end
        chk("hold_snap_total", snap_tot, 64'd12);
        out_ready = 1'b1;
        send(32'd2, 1'b0, 1'b1);
        chk("hs_to_accept", 64'(acc_cyc - hs_cyc), 64'd1);
        idle(3);

        // ACC_WIDTH=34 overflow behaviour
        sel = 1;
        pulse_rst();
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1);
        idle(3);
        chk("w34_two_total", last_tot, 64'h3_FFFF_FFFE);
        chk("w34_two_ovf", 64'(last_ovf), 64'd0);
        for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 1'b1, i == 2);
        idle(3);
        chk("w34_three_total", last_tot, 64'h1_FFFF_FFFD);
        chk("w34_three_ovf", 64'(last_ovf), 64'd1);
        send(32'd1, 1'b0, 1'b1);
        idle(3);
        chk("w34_next_ovf", 64'(last_ovf), 64'd0);

        // CNT_WIDTH=2 forced close
        sel = 2;
        pulse_rst();
        for (int i = 0; i < 4; i++) send(32'd1, 1'b0, 1'b0);
        idle(3);
        chk("c2_count", last_cnt, 64'd4);
        chk("c2_total", last_tot, 64'd4);
        chk("c2_forced", 64'(last_frc), 64'd1);
        send(32'd1, 1'b0, 1'b1);
        idle(3);
        chk("c2_next_count", last_cnt, 64'd1);
        chk("c2_next_forced", 64'(last_frc), 64'd0);

        // reset mid-frame
        sel = 0;
        pulse_rst();
        ov_cycles = 0;
        send(32'd1, 1'b0, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        pulse_rst();
        idle(3);
        chk("midrst_no_out", 64'(ov_cycles), 64'd0);
        send(32'd7, 1'b0, 1'b1);
        idle(3);
        chk("midrst_total", last_tot, 64'd7);
        chk("midrst_count", last_cnt, 64'd1);

        chk("leftover_results", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Streaming accumulator that sits directly downstream of `adder_32bit`. It consumes the adder's 32-bit sum and carry-out as one 33-bit term per handshake and adds the terms of a frame into a wide total. When the frame ends it presents the total, the term count and status flags, and holds them until the consumer accepts.

## Interface
Parameters:
- `ACC_WIDTH`, default 41: accumulator width in bits; must be ≥ 33.
- `CNT_WIDTH`, default 8: a frame holds at most 2^CNT_WIDTH terms.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: a term is present on `in_sum`/`in_carry`.
- `in_ready`  out  1: block accepts a term this cycle.
- `in_sum`  in  32: adder sum S.
- `in_carry`  in  1: adder carry C32.
- `in_last`  in  1: the term is the last of its frame.
- `out_valid`  out  1: frame result is available.
- `out_ready`  in  1: consumer accepts the result.
- `out_total`  out  ACC_WIDTH: frame sum, modulo 2^ACC_WIDTH.
- `out_count`  out  CNT_WIDTH+1: number of terms in the frame (1..2^CNT_WIDTH).
- `out_overflow`  out  1: sticky; a carry left bit ACC_WIDTH-1 during this frame.
- `out_forced`  out  1: the frame was closed by the count limit, not by `in_last`.

## Operation
- Term value = {in_carry, in_sum}, zero-extended to ACC_WIDTH.
- Input handshake: a term is accepted on an edge where in_valid && in_ready.
- Output handshake: the result is consumed on an edge where out_valid && out_ready.
- States:
  - ACCUM: in_ready = 1 (0 while rst is high); out_valid = 0.
  - DONE: in_ready = 0; out_valid = 1.
- ACCUM, accept:
  - acc <= acc + term, truncated to ACC_WIDTH.
  - ovf <= ovf | carry-out of that add.
  - cnt <= cnt + 1.
- ACCUM → DONE on an accepted term when either:
  - in_last = 1 (out_forced = 0), or
  - the new count equals 2^CNT_WIDTH (out_forced = 1, regardless of in_last).
- On the transition into DONE, out_total, out_count and out_overflow are loaded with the post-add values.
- DONE → ACCUM on output handshake: acc, cnt and ovf clear to 0.
- out_* registers hold their values until the next DONE entry. They are only meaningful while out_valid = 1.
- ACCUM with no accept: all state holds.
- DONE without out_ready: all outputs hold stable. in_valid is ignored (in_ready = 0).
- in_sum, in_carry and in_last are don't-care unless in_valid && in_ready.

## Timing
- Reset (rst high at an edge):
  - state = ACCUM; acc, cnt, ovf = 0.
  - out_valid = 0, out_total = 0, out_count = 0, out_overflow = 0, out_forced = 0.
  - in_ready is combinationally 0 while rst = 1 and 1 in the first cycle after.
- Reset mid-frame or in DONE discards the partial frame or the pending result. No output is produced.
- Throughput: one term per cycle in ACCUM.
- Latency: last term accepted at edge k → out_valid = 1 from edge k through the output handshake edge.
- After the output handshake at edge m, in_ready = 1 from edge m. This gives exactly one non-accepting cycle (the DONE cycle) per frame when out_ready is held high.
- Single-term frame: in_last on the first term → out_count = 1, out_total = term.
- out_valid never drops without a handshake, except on reset.

## Test plan
- Reset, then frame of 3 terms (S=0xFFFFFFFF,C=1), (S=1,C=0), (S=5,C=0) with last on the third, out_ready = 1:
  - out_total = 0x1_FFFF_FFFF + 6 = 0x2_0000_0005, out_count = 3, overflow = 0, forced = 0.
  - out_valid is high for exactly 1 cycle.
- 100 random adder (A,B) pairs, fed with S = (A+B)[31:0], C = (A+B)[32], last on the 100th:
  - out_total equals the 64-bit reference sum of all A+B, truncated to 41 bits.
  - out_count = 100.
- out_ready held low 5 cycles after DONE with in_valid = 1 throughout:
  - in_ready = 0 and outputs are stable for all 5 cycles.
  - The next frame's first term is accepted on the handshake edge + 1 cycle.
- ACC_WIDTH=34, two terms of 0x1_FFFF_FFFF each:
  - out_total = 0x3_FFFF_FFFE (no overflow).
  - A third such term gives out_total = 0x1_FFFF_FFFD and out_overflow = 1.
  - The next frame reports out_overflow = 0.
- CNT_WIDTH=2, 4 terms of value 1 with in_last never set:
  - DONE after the 4th term with out_count = 4, out_total = 4, out_forced = 1.
  - A 5th term starts a new frame.
- rst pulsed for 1 cycle after 2 accepted terms:
  - No out_valid is produced.
  - The following single-term frame (S=7,C=0,last) yields out_total = 7, out_count = 1.
